// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM command sequencer.
package sdram_pkg;

   localparam int unsigned CMD_W  = 3;
   localparam int unsigned MODE_W = 10;
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned TLAT_W = 3;
   localparam int unsigned AP_BIT = 10;

   // MODE_WORD field positions
   localparam int unsigned MODE_BL_LSB = 0;
   localparam int unsigned MODE_BL_W   = 3;
   localparam int unsigned MODE_CL_LSB = 4;
   localparam int unsigned MODE_CL_W   = 2;

   // {ras_n, cas_n, we_n}
   localparam logic [CMD_W-1:0] CMD_NOP   = 3'b111;
   localparam logic [CMD_W-1:0] CMD_ACT   = 3'b011;
   localparam logic [CMD_W-1:0] CMD_READ  = 3'b101;
   localparam logic [CMD_W-1:0] CMD_WRITE = 3'b100;
   localparam logic [CMD_W-1:0] CMD_PRE   = 3'b010;
   localparam logic [CMD_W-1:0] CMD_REF   = 3'b001;
   localparam logic [CMD_W-1:0] CMD_MRS   = 3'b000;

   typedef enum logic [3:0] {
      ST_INIT_PRE = 4'd0,
      ST_INIT_PW  = 4'd1,
      ST_MRS      = 4'd2,
      ST_MRS_W    = 4'd3,
      ST_IDLE     = 4'd4,
      ST_REF      = 4'd5,
      ST_REF_W    = 4'd6,
      ST_ACT      = 4'd7,
      ST_ACT_W    = 4'd8,
      ST_RW       = 4'd9,
      ST_CAS_W    = 4'd10,
      ST_LAT_W    = 4'd11,
      ST_BURST    = 4'd12,
      ST_BURST_W  = 4'd13,
      ST_PRE      = 4'd14,
      ST_PRE_W    = 4'd15
   } state_t;

endpackage

// File: rtl/sdram_lat_counter.sv
// CAS-latency down-counter used while waiting for read data.
module sdram_lat_counter
   import sdram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [TLAT_W-1:0] load_val,
   output logic              last_c
);

   logic [TLAT_W-1:0] cnt_q;
   logic [TLAT_W-1:0] cnt_d;

   // load on entry, otherwise count down and stick at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != TLAT_W'(0)) begin
         cnt_d = cnt_q - TLAT_W'(1);
      end
   end

   // counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // last wait cycle: a count of 0 or 1 reaches zero on the next edge
   assign last_c = (cnt_q <= TLAT_W'(1));

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: init, mode set, refresh and single-burst transfers.
module sdram_cmd_sequencer
   import sdram_pkg::*;
#(
   parameter int unsigned ROW_W     = 12,
   parameter int unsigned COL_W     = 8,
   parameter int unsigned BANK_W    = 2,
   parameter logic [9:0]  MODE_WORD = 10'h013
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [CNT_W-1:0]              countout,
   input  logic [TLAT_W-1:0]             tlat,
   input  logic                          host_req,
   input  logic                          host_wr,
   input  logic [BANK_W+ROW_W+COL_W-1:0] host_addr,
   input  logic                          refresh_req,
   output logic                          refresh_ack,
   output logic                          host_ack,
   output logic                          busy,
   output logic                          data_phase,
   output logic                          load_tpre,
   output logic                          load_twait,
   output logic                          load_tcas,
   output logic                          load_tburst,
   output logic [MODE_W-1:0]             program_data,
   output logic                          sd_cs_n,
   output logic                          sd_ras_n,
   output logic                          sd_cas_n,
   output logic                          sd_we_n,
   output logic [BANK_W-1:0]             sd_ba,
   output logic [ROW_W-1:0]              sd_addr
);

   localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;

   state_t              state_q, state_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic [BANK_W-1:0]   ba_q, ba_d;
   logic [ROW_W-1:0]    sd_addr_q, sd_addr_d;
   logic                ld_tpre_q, ld_tpre_d;
   logic                ld_twait_q, ld_twait_d;
   logic                ld_tcas_q, ld_tcas_d;
   logic                ld_tburst_q, ld_tburst_d;
   logic                host_ack_q, host_ack_d;
   logic                refresh_ack_q, refresh_ack_d;
   logic                data_phase_q, data_phase_d;
   logic                busy_q, busy_d;
   logic                cnt_zero_c;
   logic                lat_load_c;
   logic                lat_last_c;

   assign cnt_zero_c = (countout == CNT_W'(0));

   sdram_lat_counter u_lat (
      .clk      (clk),
      .rst      (reset),
      .load     (lat_load_c),
      .load_val (tlat),
      .last_c   (lat_last_c)
   );

   // next state, then outputs decoded from the next state so registers line up with it
   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      addr_d        = addr_q;
      host_ack_d    = 1'b0;
      lat_load_c    = 1'b0;
      cmd_d         = CMD_NOP;
      ba_d          = '0;
      sd_addr_d     = '0;
      ld_tpre_d     = 1'b0;
      ld_twait_d    = 1'b0;
      ld_tcas_d     = 1'b0;
      ld_tburst_d   = 1'b0;
      refresh_ack_d = 1'b0;
      data_phase_d  = 1'b0;
      busy_d        = 1'b1;

      case (state_q)
         // first cycle after reset is a NOP; leave once the PRE has been driven
         ST_INIT_PRE: if (ld_tpre_q) state_d = ST_INIT_PW;
         ST_INIT_PW:  if (cnt_zero_c) state_d = ST_MRS;
         ST_MRS:      state_d = ST_MRS_W;
         ST_MRS_W:    if (cnt_zero_c) state_d = ST_IDLE;
         ST_IDLE: begin
            // host still sees its ack this cycle, so its request is stale
            if (refresh_req) begin
               state_d = ST_REF;
            end else if (host_req && !host_ack_q) begin
               wr_d    = host_wr;
               addr_d  = host_addr;
               state_d = ST_ACT;
            end
         end
         ST_REF:      state_d = ST_REF_W;
         ST_REF_W:    if (cnt_zero_c) state_d = ST_IDLE;
         ST_ACT:      state_d = ST_ACT_W;
         ST_ACT_W:    if (cnt_zero_c) state_d = ST_RW;
         ST_RW:       state_d = ST_CAS_W;
         ST_CAS_W:    if (cnt_zero_c) state_d = wr_q ? ST_BURST : ST_LAT_W;
         ST_LAT_W:    if (lat_last_c) state_d = ST_BURST;
         ST_BURST:    state_d = ST_BURST_W;
         ST_BURST_W:  if (cnt_zero_c) state_d = ST_PRE;
         ST_PRE:      state_d = ST_PRE_W;
         ST_PRE_W: begin
            if (cnt_zero_c) begin
               state_d    = ST_IDLE;
               host_ack_d = 1'b1;
            end
         end
         default:     state_d = ST_INIT_PRE;
      endcase

      lat_load_c = (state_d == ST_LAT_W) && (state_q != ST_LAT_W);
      busy_d     = (state_d != ST_IDLE);

      case (state_d)
         ST_INIT_PRE: begin
            cmd_d             = CMD_PRE;
            sd_addr_d[AP_BIT] = 1'b1;
            ld_tpre_d         = 1'b1;
         end
         ST_MRS: begin
            cmd_d      = CMD_MRS;
            sd_addr_d  = ROW_W'(MODE_WORD);
            ld_twait_d = 1'b1;
         end
         ST_REF: begin
            cmd_d         = CMD_REF;
            ld_twait_d    = 1'b1;
            refresh_ack_d = 1'b1;
         end
         ST_ACT: begin
            cmd_d      = CMD_ACT;
            ba_d       = addr_d[ADDR_W-1 -: BANK_W];
            sd_addr_d  = addr_d[COL_W +: ROW_W];
            ld_twait_d = 1'b1;
         end
         ST_RW: begin
            cmd_d             = wr_d ? CMD_WRITE : CMD_READ;
            ba_d              = addr_d[ADDR_W-1 -: BANK_W];
            sd_addr_d         = ROW_W'(addr_d[COL_W-1:0]);
            sd_addr_d[AP_BIT] = 1'b0;
            ld_tcas_d         = 1'b1;
         end
         ST_BURST:   ld_tburst_d  = 1'b1;
         ST_BURST_W: data_phase_d = 1'b1;
         ST_PRE: begin
            cmd_d     = CMD_PRE;
            ba_d      = addr_d[ADDR_W-1 -: BANK_W];
            ld_tpre_d = 1'b1;
         end
         default: ;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_INIT_PRE;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         cmd_q         <= CMD_NOP;
         ba_q          <= '0;
         sd_addr_q     <= '0;
         ld_tpre_q     <= 1'b0;
         ld_twait_q    <= 1'b0;
         ld_tcas_q     <= 1'b0;
         ld_tburst_q   <= 1'b0;
         host_ack_q    <= 1'b0;
         refresh_ack_q <= 1'b0;
         data_phase_q  <= 1'b0;
         busy_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         addr_q        <= addr_d;
         cmd_q         <= cmd_d;
         ba_q          <= ba_d;
         sd_addr_q     <= sd_addr_d;
         ld_tpre_q     <= ld_tpre_d;
         ld_twait_q    <= ld_twait_d;
         ld_tcas_q     <= ld_tcas_d;
         ld_tburst_q   <= ld_tburst_d;
         host_ack_q    <= host_ack_d;
         refresh_ack_q <= refresh_ack_d;
         data_phase_q  <= data_phase_d;
         busy_q        <= busy_d;
      end
   end

   // chip stays selected; NOP is expressed on ras/cas/we
   assign sd_cs_n      = 1'b0;
   assign program_data = MODE_WORD;
   assign sd_ras_n     = cmd_q[2];
   assign sd_cas_n     = cmd_q[1];
   assign sd_we_n      = cmd_q[0];
   assign sd_ba        = ba_q;
   assign sd_addr      = sd_addr_q;
   assign load_tpre    = ld_tpre_q;
   assign load_twait   = ld_twait_q;
   assign load_tcas    = ld_tcas_q;
   assign load_tburst  = ld_tburst_q;
   assign host_ack     = host_ack_q;
   assign refresh_ack  = refresh_ack_q;
   assign data_phase   = data_phase_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer with a behavioural delay generator attached.
module tb_sdram_cmd_sequencer;
   import sdram_pkg::*;

   localparam int unsigned TPRE  = 2;
   localparam int unsigned TWAIT = 2;
   localparam int unsigned TCAS  = 2;

   typedef struct packed {
      logic [2:0]  cmd;
      logic [1:0]  ba;
      logic [11:0] addr;
      logic [3:0]  ld;
      logic        rack;
      logic        hack;
      logic [15:0] gap;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  countout;
   logic [2:0]  tlat;
   logic        host_req = 1'b0;
   logic        host_wr = 1'b0;
   logic [21:0] host_addr = '0;
   logic        refresh_req = 1'b0;
   logic        refresh_ack, host_ack, busy, data_phase;
   logic        load_tpre, load_twait, load_tcas, load_tburst;
   logic [9:0]  program_data;
   logic        sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
   logic [1:0]  sd_ba;
   logic [11:0] sd_addr;

   sdram_cmd_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .countout     (countout),
      .tlat         (tlat),
      .host_req     (host_req),
      .host_wr      (host_wr),
      .host_addr    (host_addr),
      .refresh_req  (refresh_req),
      .refresh_ack  (refresh_ack),
      .host_ack     (host_ack),
      .busy         (busy),
      .data_phase   (data_phase),
      .load_tpre    (load_tpre),
      .load_twait   (load_twait),
      .load_tcas    (load_tcas),
      .load_tburst  (load_tburst),
      .program_data (program_data),
      .sd_cs_n      (sd_cs_n),
      .sd_ras_n     (sd_ras_n),
      .sd_cas_n     (sd_cas_n),
      .sd_we_n      (sd_we_n),
      .sd_ba        (sd_ba),
      .sd_addr      (sd_addr)
   );

   always #5 clk = ~clk;

   // delay generator model: reload on load pulses, count down to zero and hold
   logic       full_page = 1'b0;
   logic [2:0] bl_code;
   logic [9:0] burst_len;
   logic [9:0] dg_cnt;
   assign bl_code   = full_page ? 3'b111 : program_data[MODE_BL_LSB +: MODE_BL_W];
   assign burst_len = (bl_code == 3'b111) ? 10'd1023 : (10'd1 << bl_code);
   assign tlat      = 3'(program_data[MODE_CL_LSB +: MODE_CL_W]) + 3'd2;
   assign countout  = dg_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset)            dg_cnt <= '0;
      else if (load_tpre)   dg_cnt <= 10'(TPRE);
      else if (load_twait)  dg_cnt <= 10'(TWAIT);
      else if (load_tcas)   dg_cnt <= 10'(TCAS);
      else if (load_tburst) dg_cnt <= burst_len;
      else if (dg_cnt != 0) dg_cnt <= dg_cnt - 10'd1;
   end

   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    last_ev = 0;
   int    dp_run = 0;
   ev_t   sb[$];
   string sb_tag[$];
   int    dp_exp[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // gap == 0 means the distance from the previous event is not checked
   task automatic exp_ev(input string tag, input logic [2:0] cmd, input logic [1:0] ba,
                         input logic [11:0] addr, input logic [3:0] ld, input logic rack,
                         input logic hack, input int gap);
      ev_t e;
      e.cmd = cmd; e.ba = ba; e.addr = addr; e.ld = ld;
      e.rack = rack; e.hack = hack; e.gap = 16'(gap);
      sb.push_back(e);
      sb_tag.push_back(tag);
   endtask

   task automatic exp_init();
      exp_ev("init_pre", CMD_PRE, 2'd0, 12'h400, 4'b1000, 1'b0, 1'b0, 0);
      exp_ev("init_mrs", CMD_MRS, 2'd0, 12'h013, 4'b0100, 1'b0, 1'b0, TPRE + 2);
   endtask

   task automatic exp_txn(input logic wr, input logic [1:0] ba, input logic [11:0] row,
                          input logic [7:0] col, input int act_gap, input int bl);
      exp_ev("act", CMD_ACT, ba, row, 4'b0100, 1'b0, 1'b0, act_gap);
      if (wr) exp_ev("write", CMD_WRITE, ba, 12'(col), 4'b0010, 1'b0, 1'b0, TWAIT + 2);
      else    exp_ev("read",  CMD_READ,  ba, 12'(col), 4'b0010, 1'b0, 1'b0, TWAIT + 2);
      // a read adds three CAS-latency cycles before the burst
      exp_ev("burst", CMD_NOP, 2'd0, 12'd0, 4'b0001, 1'b0, 1'b0, TCAS + 2 + (wr ? 0 : 3));
      exp_ev("pre", CMD_PRE, ba, 12'd0, 4'b1000, 1'b0, 1'b0, bl + 2);
      exp_ev("host_ack", CMD_NOP, 2'd0, 12'd0, 4'b0000, 1'b0, 1'b1, TPRE + 2);
      dp_exp.push_back(bl + 1);
   endtask

   // advance one cycle and compare whatever the DUT produced
   task automatic tick();
      ev_t o, e;
      @(negedge clk);
      cyc++;
      if (!reset) begin
         if (data_phase) begin
            dp_run++;
         end else if (dp_run != 0) begin
            if (dp_exp.size() != 0) check("data_phase_len", 64'(dp_run), 64'(dp_exp.pop_front()));
            else check("data_phase_unexpected", 64'(dp_run), 64'(0));
            dp_run = 0;
         end
         if ({sd_ras_n, sd_cas_n, sd_we_n} != CMD_NOP || load_tpre || load_twait ||
             load_tcas || load_tburst || host_ack || refresh_ack) begin
            o.cmd  = {sd_ras_n, sd_cas_n, sd_we_n};
            o.ba   = sd_ba;
            o.addr = sd_addr;
            o.ld   = {load_tpre, load_twait, load_tcas, load_tburst};
            o.rack = refresh_ack;
            o.hack = host_ack;
            o.gap  = 16'(cyc - last_ev);
            last_ev = cyc;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               if (e.gap == 16'd0) o.gap = 16'd0;
               check(sb_tag.pop_front(), 64'(o), 64'(e));
            end else begin
               check("unexpected_event", 64'(o), 64'(0));
            end
         end
      end
   endtask

   // run until all expectations are consumed and the sequencer is idle again
   task automatic run(input string tag, input int budget);
      int  n = 0;
      bit  done = 1'b0;
      while (!done && n < budget) begin
         tick();
         n++;
         if (host_ack) host_req = 1'b0;
         if (refresh_ack) refresh_req = 1'b0;
         done = (sb.size() == 0) && (dp_exp.size() == 0) && !busy && !host_req && !refresh_req;
      end
      check({tag, "_pending"}, 64'(sb.size() + dp_exp.size()), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      check("reset_cmd", 64'({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}), 64'(4'b0111));
      check("reset_addr", 64'({sd_ba, sd_addr}), 64'(0));
      check("reset_flags", 64'({load_tpre, load_twait, load_tcas, load_tburst, host_ack,
                                refresh_ack, data_phase, busy}), 64'(8'b0000_0001));
      check("program_data", 64'(program_data), 64'(10'h013));

      // init sequence
      reset = 1'b0;
      exp_init();
      run("init", 200);

      // read {1,0x123,0x45}
      host_wr = 1'b0; host_addr = {2'd1, 12'h123, 8'h45}; host_req = 1'b1;
      exp_txn(1'b0, 2'd1, 12'h123, 8'h45, 0, 8);
      run("read", 200);

      // write with the same address
      host_wr = 1'b1; host_req = 1'b1;
      exp_txn(1'b1, 2'd1, 12'h123, 8'h45, 0, 8);
      run("write", 200);

      // refresh and host together: refresh first, ACT right after REF_W
      refresh_req = 1'b1;
      host_wr = 1'b1; host_addr = {2'd2, 12'habc, 8'h7f}; host_req = 1'b1;
      exp_ev("refresh", CMD_REF, 2'd0, 12'd0, 4'b0100, 1'b1, 1'b0, 0);
      exp_txn(1'b1, 2'd2, 12'habc, 8'h7f, TWAIT + 3, 8);
      run("ref_host", 300);

      // full-page burst code
      full_page = 1'b1;
      host_wr = 1'b1; host_addr = {2'd3, 12'h001, 8'hff}; host_req = 1'b1;
      exp_txn(1'b1, 2'd3, 12'h001, 8'hff, 0, 1023);
      run("full_page", 2000);
      full_page = 1'b0;

      // reset during BURST_W aborts the read without an ack
      host_wr = 1'b0; host_addr = {2'd0, 12'h055, 8'h0a}; host_req = 1'b1;
      exp_txn(1'b0, 2'd0, 12'h055, 8'h0a, 0, 8);
      for (int i = 0; i < 100 && dp_run < 3; i++) tick();
      check("abort_in_burst", 64'(data_phase), 64'(1));
      #2 reset = 1'b1;
      #1;
      check("abort_outputs", 64'({sd_ras_n, sd_cas_n, sd_we_n, load_tpre, load_twait,
                                  load_tcas, load_tburst, data_phase, busy, host_ack}),
            64'({CMD_NOP, 4'b0000, 1'b0, 1'b1, 1'b0}));
      sb.delete();
      sb_tag.delete();
      dp_exp.delete();
      dp_run = 0;
      host_req = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      exp_init();
      run("reinit", 200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_sequencer.md
Name: sdram_cmd_sequencer

Overview:
- Command-issuing FSM for the SDRAM controller. Sits directly upstream of the delay generator.
- Drives the delay generator's load_tpre / load_twait / load_tcas / load_tburst pulses and its program_data input.
- Consumes its countout and tlat to time every phase.
- Sequences power-up init, mode-register set, auto-refresh, and single-burst read/write transactions on the SDRAM command/address pins.
- Presents a req/ack handshake to the host side.

Parameters:
ROW_W, 12, row address width
COL_W, 8, column address width
BANK_W, 2, bank address width
MODE_WORD, 10'h013, mode word driven on program_data and on the address bus in MRS; bits[2:0] = burst-length code (burst 8), bits[5:4] = latency code (CAS latency 3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
countout  in  10  remaining-delay count from delay generator
tlat  in  3  CAS latency reported by delay generator
host_req  in  1  transaction request; held until host_ack
host_wr  in  1  1 = write, 0 = read; sampled with host_req
host_addr  in  BANK_W+ROW_W+COL_W  {bank,row,col}; sampled with host_req
refresh_req  in  1  refresh request level from refresh timer
refresh_ack  out  1  one-cycle pulse when the REFRESH command issues
host_ack  out  1  one-cycle pulse at the end of a transaction's precharge wait
busy  out  1  high in every state except IDLE
data_phase  out  1  high for every cycle of BURST_W
load_tpre, load_twait, load_tcas, load_tburst  out  1 each  delay-generator reload pulses
program_data  out  10  constant MODE_WORD
sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  out  1 each  SDRAM command pins
sd_ba  out  BANK_W  bank address
sd_addr  out  ROW_W  row/column/mode address

Behaviour:
- All outputs registered. On reset assertion: state = INIT_PRE, command = NOP (cs_n=0, ras_n=cas_n=we_n=1), sd_addr=0, sd_ba=0, all load_* = 0, host_ack=0, refresh_ack=0, data_phase=0, busy=1. program_data = MODE_WORD always.
- Command encodings {ras_n,cas_n,we_n}:
  - ACT 011, READ 101, WRITE 100, PRE 010, REF 001, MRS 000, NOP 111.
  - Command states drive their command for exactly one cycle; all other cycles drive NOP.
- Load pulses: each command state raises exactly one load_* for that same single cycle. The delay generator reloads on that edge, so countout holds the loaded value in the first cycle of the following wait state.
- Wait states exit in the cycle after the one in which countout == 0 is sampled.
- State transitions:
  - INIT_PRE (PRE, sd_addr[10]=1, load_tpre) -> INIT_PW.
  - INIT_PW -> MRS when countout == 0.
  - MRS (sd_addr = MODE_WORD zero-extended, load_twait) -> MRS_W.
  - MRS_W -> IDLE when countout == 0.
  - IDLE: refresh_req has priority over host_req.
    - refresh_req -> REF (load_twait, refresh_ack) -> REF_W; REF_W -> IDLE when countout == 0.
    - host_req: latch wr/addr -> ACT (sd_ba, sd_addr = row, load_twait) -> ACT_W.
  - ACT_W -> RW when countout == 0.
  - RW (READ or WRITE, sd_addr = col zero-extended, sd_addr[10]=0, load_tcas) -> CAS_W.
  - CAS_W: when countout == 0, a write goes to BURST; a read goes to LAT_W.
  - LAT_W: internal 3-bit counter loaded with tlat on entry; decrements each cycle; -> BURST when it reaches 0. tlat = 0 passes through LAT_W in one cycle.
  - BURST (load_tburst) -> BURST_W; data_phase=1 throughout BURST_W.
  - BURST_W -> PRE when countout == 0.
  - PRE (sd_addr[10]=0, bank = latched, load_tpre) -> PRE_W.
  - PRE_W -> IDLE when countout == 0, with a host_ack pulse in that exit cycle.
- host_req/refresh_req are ignored outside IDLE. A request arriving mid-transaction is served on return to IDLE. Simultaneous requests: refresh first, host next.
- Burst code 3'b111 yields a 1023-cycle countout (full page) and is handled with no special case.
- Reset mid-operation aborts immediately to INIT_PRE and repeats the full init. No host_ack is issued for the aborted transaction.
- Illegal state encodings recover to INIT_PRE.

Decomposition:
- Shared package sdram_pkg holds:
  - the state enum
  - command encoding constants (CMD_NOP/ACT/READ/WRITE/PRE/REF/MRS)
  - MODE_WORD field positions
- One natural sub-module: sdram_lat_counter, the tlat load/down-counter used in LAT_W.

Test Plan:
- Reset release with the delay generator attached -> PRE with addr[10]=1 and load_tpre; 4 cycles later MRS with sd_addr=0x013 and load_twait; IDLE reached, busy=0.
- Read: host_req, wr=0, addr {1,0x123,0x45} -> ACT ba=1 addr=0x123; RW READ addr=0x045; LAT_W lasts 3 cycles (tlat=3); data_phase high 9 cycles (load 8 through 0); PRE; host_ack one pulse.
- Write with the same address -> no LAT_W; BURST follows CAS_W directly; single host_ack.
- refresh_req and host_req asserted together in IDLE -> REF first with refresh_ack; ACT follows after REF_W completes.
- reset asserted during BURST_W -> outputs NOP, load_* = 0 asynchronously; init sequence restarts; no host_ack.
- MODE_WORD = 10'h017 -> data_phase lasts 1024 cycles; PRE issued afterwards.
